// File: rtl/mul64_iter.sv
// Iterative unsigned 64x64->128 shift-add multiplier driving an external 64-bit adder.
// Optional early termination when the remaining multiplier bits are zero: define MUL64_EARLY_TERM_EN.
module mul64_iter #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_c0,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
`ifdef MUL64_EARLY_TERM_EN
  localparam logic [CNT_W-1:0] W_C  = CNT_W'(WIDTH);
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mq_q, mq_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   plo_q, plo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  // The adder mux is live in every state; its result only matters in RUN.
  assign add_a   = acc_q;
  assign add_b   = mq_q[0] ? mcand_q : '0;
  assign add_c0  = 1'b0;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mq_d      = mq_q;
    acc_d     = acc_q;
    plo_d     = plo_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          mcand_d = op_a;
          mq_d    = op_b;
          acc_d   = '0;
          plo_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef MUL64_EARLY_TERM_EN
        // Partial product sits in the top WIDTH+cnt bits of {acc,plo}.
        if (mq_q == '0) begin
          product_d = {acc_q, plo_q} >> (W_C - cnt_q);
          state_d   = DONE;
        end else begin
`endif
          acc_d = {add_cf, add_sum[WIDTH-1:1]};
          plo_d = {add_sum[0], plo_q[WIDTH-1:1]};
          mq_d  = mq_q >> 1;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            product_d = {add_cf, add_sum, plo_q[WIDTH-1:1]};
            state_d   = DONE;
          end
`ifdef MUL64_EARLY_TERM_EN
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mq_q      <= '0;
      acc_q     <= '0;
      plo_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mq_q      <= mq_d;
      acc_q     <= acc_d;
      plo_q     <= plo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

endmodule
